// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm
//   Bit-serial WIDTH-bit adder built around one full-adder cell and a
//   registered carry. A start pulse loads A, B and Cin; one bit is processed
//   per clock, LSB first. The WIDTH-bit sum and carry-out appear together
//   with a one-cycle done pulse and hold until the next completion.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   load request, honoured in IDLE or DONE only
//   A, B   in   WIDTH-bit operands, captured on the accepting edge
//   Cin    in   carry-in, captured on the accepting edge
//   busy   out  high while bits are being processed (SHIFT)
//   done   out  one-cycle pulse, Sum/Carry valid from this cycle
//   Sum    out  registered WIDTH-bit result
//   Carry  out  registered carry-out
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// SHIFT  | one full-adder step per edge, WIDTH edges in total
// DONE   | result just published; done=1, may accept the next start

module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Full-adder cell on the current LSBs and the running carry.
  logic               fa_s;
  logic               fa_c;
  logic [WIDTH:0]     acc_shift;
  logic               last_bit;

  assign fa_s      = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_c      = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  // New sum bit enters at the MSB; the widened vector keeps WIDTH=1 legal.
  assign acc_shift = {fa_s, acc_q};
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = Cin;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_c;
        acc_d = acc_shift[WIDTH:1];
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d   = acc_shift[WIDTH:1];
          carry_d = fa_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Sum   = sum_q;
  assign Carry = carry_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed bench for serial_adder_fsm: an 8-bit instance for timing,
// arithmetic, mid-operation disturbance, async reset and back-to-back
// operation, plus a 1-bit instance checked against the full-adder table.

module tb_serial_adder_fsm;

  logic       clk;
  logic       rst_n;

  logic       start;
  logic [7:0] A, B;
  logic       Cin;
  logic       busy, done;
  logic [7:0] Sum;
  logic       Carry;

  logic       start1;
  logic [0:0] A1, B1;
  logic       Cin1;
  logic       busy1, done1;
  logic [0:0] Sum1;
  logic       Carry1;

  int checks = 0;
  int errors = 0;

  serial_adder_fsm #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Sum(Sum), .Carry(Carry)
  );

  serial_adder_fsm #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(A1), .B(B1), .Cin(Cin1),
    .busy(busy1), .done(done1), .Sum(Sum1), .Carry(Carry1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation on the 8-bit instance, checking busy/done on every
  // edge and that the previous result stays visible during shifting.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] prev_sum, input logic prev_c,
                        input logic [7:0] exp_sum, input logic exp_c);
    A = a; B = b; Cin = cin; start = 1'b1;
    tick();
    start = 1'b0;
    check("op_busy_e0", busy, 1);
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("op_busy_mid", busy, 1);
      check("op_done_mid", done, 0);
      check("op_sum_hold", Sum, prev_sum);
      check("op_carry_hold", Carry, prev_c);
    end
    tick();
    check("op_done", done, 1);
    check("op_busy_end", busy, 0);
    check("op_sum", Sum, exp_sum);
    check("op_carry", Carry, exp_c);
    tick();
    check("op_done_drop", done, 0);
    check("op_sum_keep", Sum, exp_sum);
  endtask

  logic [1:0] fa_tab [8];
  logic [7:0] b2b_a [3];
  logic [7:0] b2b_b [3];
  logic       b2b_ci [3];
  logic [7:0] b2b_s [3];
  logic       b2b_co [3];
  int         t, prev_t, n;

  initial begin
    // {Carry,Sum} for {A,B,Cin} = 0..7
    fa_tab[0] = 2'b00; fa_tab[1] = 2'b01; fa_tab[2] = 2'b01; fa_tab[3] = 2'b10;
    fa_tab[4] = 2'b01; fa_tab[5] = 2'b10; fa_tab[6] = 2'b10; fa_tab[7] = 2'b11;

    b2b_a[0] = 8'h3C; b2b_b[0] = 8'h0F; b2b_ci[0] = 1'b0; b2b_s[0] = 8'h4B; b2b_co[0] = 1'b0;
    b2b_a[1] = 8'h80; b2b_b[1] = 8'h80; b2b_ci[1] = 1'b1; b2b_s[1] = 8'h01; b2b_co[1] = 1'b1;
    b2b_a[2] = 8'h12; b2b_b[2] = 8'h34; b2b_ci[2] = 1'b0; b2b_s[2] = 8'h46; b2b_co[2] = 1'b0;

    start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    start1 = 1'b0; A1 = '0; B1 = '0; Cin1 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", Sum, 0);
    check("rst_carry", Carry, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // Basic arithmetic
    run_op(8'h3C, 8'h0F, 1'b0, 8'h00, 1'b0, 8'h4B, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h4B, 1'b0, 8'h00, 1'b1);
    run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);

    // Start pulses and operand changes during SHIFT are ignored
    A = 8'h3C; B = 8'h0F; Cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    A = 8'h00; B = 8'h00; Cin = 1'b1; start = 1'b1;
    tick();
    check("ign_busy_e3", busy, 1);
    tick();
    tick();
    start = 1'b0;
    tick();
    tick();
    check("ign_done_e7", done, 0);
    tick();
    check("ign_done", done, 1);
    check("ign_sum", Sum, 8'h4B);
    check("ign_carry", Carry, 0);
    tick();
    check("ign_no_extra_done", done, 0);
    check("ign_idle_busy", busy, 0);
    tick();
    check("ign_no_extra_done2", done, 0);

    // Asynchronous reset between edges 4 and 5
    A = 8'hFF; B = 8'h01; Cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", Sum, 0);
    check("arst_carry", Carry, 0);
    #2 rst_n = 1'b1;
    n = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (done || busy) n++;
    end
    check("arst_no_done_after", n, 0);

    // start held high: three back-to-back operations
    A = b2b_a[0]; B = b2b_b[0]; Cin = b2b_ci[0]; start = 1'b1;
    tick();
    t = 0;
    prev_t = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        tick();
        t++;
        n++;
      end while (!done && n < 20);
      check("b2b_done", done, 1);
      check("b2b_sum", Sum, b2b_s[k]);
      check("b2b_carry", Carry, b2b_co[k]);
      check("b2b_gap", t - prev_t, (k == 0) ? 8 : 9);
      prev_t = t;
      if (k < 2) begin
        A = b2b_a[k+1]; B = b2b_b[k+1]; Cin = b2b_ci[k+1];
      end else begin
        start = 1'b0;
      end
    end
    tick();
    check("b2b_final_done", done, 0);
    check("b2b_final_busy", busy, 0);

    // WIDTH=1 instance against the full-adder truth table
    for (int i = 0; i < 8; i++) begin
      A1 = i[2]; B1 = i[1]; Cin1 = i[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("w1_busy", busy1, 1);
      check("w1_done_early", done1, 0);
      tick();
      check("w1_done", done1, 1);
      check("w1_result", {Carry1, Sum1}, fa_tab[i]);
      tick();
      check("w1_done_drop", done1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
